// File: rtl/acc_core_pkg.sv
// Shared definitions for the accumulator core: opcode values, instruction field
// width and the instruction-cycle state encoding.
package acc_core_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_LOAD  = 4'd0;
   localparam logic [OP_W-1:0] OP_STORE = 4'd1;
   localparam logic [OP_W-1:0] OP_ADD   = 4'd2;
   localparam logic [OP_W-1:0] OP_LOOP  = 4'd3;
   localparam logic [OP_W-1:0] OP_JMP   = 4'd4;
   localparam logic [OP_W-1:0] OP_BZ    = 4'd5;
   localparam logic [OP_W-1:0] OP_SETDP = 4'd6;
   localparam logic [OP_W-1:0] OP_INCDP = 4'd7;
   localparam logic [OP_W-1:0] OP_HALT  = 4'd8;

   typedef enum logic [2:0] {
      S_ADDR,
      S_FETCH,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   // LOAD and STORE are the only opcodes that steer the address bus to the data pointer.
   function automatic logic isDataOp(input logic [OP_W-1:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/acc_core_p_tick_gen.sv
// Execution tick generator: divides the system clock so that one tick is high
// for a single clock every CLK_DIV clocks.
module tick_gen #(
   parameter int CLK_DIV = 10
) (
   input  logic clock,
   input  logic reset_n,
   output logic tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div;

   assign tick = (r_div == DIV_MAX);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= '0;
      end else if (tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

endmodule

// File: rtl/acc_core_p.sv
// Parametrised accumulator core sharing one memory port between instruction
// fetch and LOAD/STORE data accesses; each instruction takes four execution ticks.
module acc_core_p
   import acc_core_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 15,
   parameter int START_ADDR = 9216,
   parameter int DATA_LIMIT = 8000,
   parameter int CLK_DIV    = 10
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] datain,
   output logic [ADDR_W-1:0] addrout,
   output logic [DATA_W-1:0] dataout,
   output logic              we,
   output logic              halted
);

   localparam int IMM_W = DATA_W - OP_W;

   state_t            r_state;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_dptr;
   logic              r_selData;
   logic              r_we;
   logic              r_halted;

   logic              w_tick;
   logic [OP_W-1:0]   w_op;
   logic [IMM_W-1:0]  w_imm;
   logic [ADDR_W-1:0] w_pcInc;
   logic [ADDR_W-1:0] w_target;
   logic [DATA_W-1:0] w_addend;

   tick_gen #(.CLK_DIV(CLK_DIV)) u_tickGen (
      .clock   (clock),
      .reset_n (reset_n),
      .tick    (w_tick)
   );

   // Any data-pointer result beyond the window folds back to address 0.
   function automatic logic [ADDR_W-1:0] boundDptr(input logic [31:0] v);
      if (v > 32'(DATA_LIMIT)) return '0;
      return ADDR_W'(v);
   endfunction

   assign w_op     = r_ir[OP_W-1:0];
   assign w_imm    = r_ir[DATA_W-1:OP_W];
   assign w_pcInc  = r_pc + ADDR_W'(1);
   assign w_target = ADDR_W'(32'(START_ADDR) + 32'(w_imm));
   assign w_addend = (w_imm == '0) ? DATA_W'(1) : DATA_W'(w_imm);

   assign addrout = r_selData ? r_dptr : r_pc;
   assign dataout = r_acc;
   assign we      = r_we;
   assign halted  = r_halted;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_ADDR;
         r_acc     <= '0;
         r_ir      <= '0;
         r_pc      <= ADDR_W'(START_ADDR);
         r_dptr    <= '0;
         r_selData <= 1'b0;
         r_we      <= 1'b0;
         r_halted  <= 1'b0;
      end else begin
         // Write strobe lasts exactly one clock regardless of tick timing.
         r_we <= 1'b0;
         if (w_tick) begin
            case (r_state)
               S_ADDR: r_state <= S_FETCH;
               S_FETCH: begin
                  r_ir <= datain;
                  if (isDataOp(datain[OP_W-1:0])) r_selData <= 1'b1;
                  r_state <= S_EXEC;
               end
               S_EXEC: begin
                  r_we    <= (w_op == OP_STORE);
                  r_state <= S_WB;
               end
               S_WB: begin
                  r_selData <= 1'b0;
                  r_state   <= S_ADDR;
                  case (w_op)
                     OP_LOAD: begin
                        r_acc <= datain;
                        r_pc  <= w_pcInc;
                     end
                     OP_ADD: begin
                        r_acc <= r_acc + w_addend;
                        r_pc  <= w_pcInc;
                     end
                     OP_LOOP: begin
                        r_dptr <= boundDptr(32'(r_dptr) + 32'd1);
                        r_pc   <= ADDR_W'(START_ADDR);
                     end
                     OP_JMP: r_pc <= w_target;
                     OP_BZ:  r_pc <= (r_acc == '0) ? w_target : w_pcInc;
                     OP_SETDP: begin
                        r_dptr <= boundDptr(32'(w_imm));
                        r_pc   <= w_pcInc;
                     end
                     OP_INCDP: begin
                        r_dptr <= boundDptr(32'(r_dptr) + 32'd1);
                        r_pc   <= w_pcInc;
                     end
                     OP_HALT: begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                     end
                     default: r_pc <= w_pcInc;
                  endcase
               end
               S_HALT: r_state <= S_HALT;
               default: r_state <= S_ADDR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_acc_core_p.sv
// Self-checking bench: directed programs plus random programs on a 20-bit core,
// and a small directed run on an 8-bit single-clock-tick core.
module tb_acc_core_p;

   localparam int DW   = 20;
   localparam int AW   = 15;
   localparam int SA   = 9216;
   localparam int DL   = 8000;
   localparam int CD   = 10;
   localparam int MEMA = 1 << AW;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          resetA_n;
   logic [DW-1:0] dataInA;
   logic [DW-1:0] dataOutA;
   logic [AW-1:0] addrOutA;
   logic          weA;
   logic          haltedA;
   logic [DW-1:0] memA [0:MEMA-1];

   logic          resetB_n;
   logic [7:0]    dataInB;
   logic [7:0]    dataOutB;
   logic [9:0]    addrOutB;
   logic          weB;
   logic          haltedB;
   logic [7:0]    memB [0:1023];

   assign dataInA = memA[addrOutA];
   assign dataInB = memB[addrOutB];

   acc_core_p #(
      .DATA_W(DW), .ADDR_W(AW), .START_ADDR(SA), .DATA_LIMIT(DL), .CLK_DIV(CD)
   ) dutA (
      .clock(clock), .reset_n(resetA_n), .datain(dataInA), .addrout(addrOutA),
      .dataout(dataOutA), .we(weA), .halted(haltedA)
   );

   acc_core_p #(
      .DATA_W(8), .ADDR_W(10), .START_ADDR(0), .DATA_LIMIT(1000), .CLK_DIV(1)
   ) dutB (
      .clock(clock), .reset_n(resetB_n), .datain(dataInB), .addrout(addrOutB),
      .dataout(dataOutB), .we(weB), .halted(haltedB)
   );

   // Architectural reference state: what the program should have done so far.
   int            mAcc;
   int            mPc;
   int            mDptr;
   bit            mHalted;
   logic [DW-1:0] mMem [0:MEMA-1];

   int nChecks = 0;
   int nPass   = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advances n clocks; memory A captures a write whenever we is high at the edge.
   task automatic tickClock(input int n);
      for (int i = 0; i < n; i++) begin
         logic          w;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         w = weA;
         a = addrOutA;
         d = dataOutA;
         @(posedge clock);
         #1;
         if (w) memA[a] = d;
      end
   endtask

   function automatic int bound(input int v);
      return (v > DL) ? 0 : v;
   endfunction

   task automatic putWord(input int addr, input logic [DW-1:0] w);
      memA[addr] = w;
      mMem[addr] = w;
   endtask

   task automatic clearMem(input bit randomData);
      for (int i = 0; i < MEMA; i++) putWord(i, '0);
      if (randomData)
         for (int i = 0; i < 8192; i++) putWord(i, DW'($urandom));
   endtask

   task automatic resetA();
      resetA_n = 1'b0;
      tickClock(2);
      resetA_n = 1'b1;
      mAcc = 0;
      mPc = SA;
      mDptr = 0;
      mHalted = 1'b0;
      checkOutput("reset addrout", 32'(addrOutA), 32'(SA));
      checkOutput("reset dataout", 32'(dataOutA), 32'd0);
      checkOutput("reset we", 32'(weA), 32'd0);
      checkOutput("reset halted", 32'(haltedA), 32'd0);
   endtask

   // Runs one four-tick instruction slot, checking the bus at each phase and
   // the architectural result afterwards.
   task automatic applyStimulus();
      logic [DW-1:0] word;
      int op, imm, dOld;
      bit ldst, st;
      if (mHalted) begin
         tickClock(4 * CD);
         checkOutput("halted stays", 32'(haltedA), 32'd1);
         checkOutput("halted addr", 32'(addrOutA), 32'(mPc));
         checkOutput("halted we", 32'(weA), 32'd0);
         return;
      end
      word = mMem[mPc];
      op   = int'(word[3:0]);
      imm  = int'(word[DW-1:4]);
      ldst = (op <= 1);
      st   = (op == 1);
      tickClock(CD);
      checkOutput("fetch addr", 32'(addrOutA), 32'(mPc));
      checkOutput("fetch halted", 32'(haltedA), 32'd0);
      tickClock(CD);
      checkOutput("data addr", 32'(addrOutA), 32'(ldst ? mDptr : mPc));
      tickClock(CD);
      checkOutput("store we", 32'(weA), 32'(st));
      if (st) begin
         checkOutput("store data", 32'(dataOutA), 32'(mAcc));
         checkOutput("store addr", 32'(addrOutA), 32'(mDptr));
      end
      tickClock(1);
      checkOutput("we one clock", 32'(weA), 32'd0);
      tickClock(CD - 2);
      checkOutput("acc before wb", 32'(dataOutA), 32'(mAcc));
      tickClock(1);
      dOld = mDptr;
      case (op)
         0: begin mAcc = int'(mMem[mDptr]); mPc = (mPc + 1) % MEMA; end
         1: begin mMem[mDptr] = DW'(mAcc); mPc = (mPc + 1) % MEMA; end
         2: begin mAcc = (mAcc + ((imm == 0) ? 1 : imm)) % (1 << DW); mPc = (mPc + 1) % MEMA; end
         3: begin mDptr = bound(mDptr + 1); mPc = SA; end
         4: mPc = (SA + imm) % MEMA;
         5: mPc = (mAcc == 0) ? (SA + imm) % MEMA : (mPc + 1) % MEMA;
         6: begin mDptr = bound(imm); mPc = (mPc + 1) % MEMA; end
         7: begin mDptr = bound(mDptr + 1); mPc = (mPc + 1) % MEMA; end
         8: mHalted = 1'b1;
         default: mPc = (mPc + 1) % MEMA;
      endcase
      checkOutput("pc after wb", 32'(addrOutA), 32'(mPc));
      checkOutput("acc after wb", 32'(dataOutA), 32'(mAcc));
      checkOutput("halted after wb", 32'(haltedA), 32'(mHalted));
      if (st) checkOutput("mem after store", 32'(memA[dOld]), 32'(mMem[dOld]));
   endtask

   function automatic logic [DW-1:0] randomWord();
      int op, imm, r;
      op = $urandom_range(0, 15);
      if (op == 8 && $urandom_range(0, 2) != 0) op = 2;
      imm = $urandom_range(0, 65535);
      if (op == 4 || op == 5) imm = $urandom_range(0, 15);
      if (op == 6) begin
         r = $urandom_range(0, 3);
         if (r == 0) imm = $urandom_range(0, 8191);
         else if (r == 1) imm = $urandom_range(7995, 8005);
         else if (r == 3) imm = $urandom_range(0, 20);
      end
      return DW'((imm << 4) | op);
   endfunction

   initial begin
      resetA_n = 1'b0;
      resetB_n = 1'b0;
      for (int i = 0; i < 1024; i++) memB[i] = '0;
      $display("[TB] start");

      // ADD (legacy increment) then HALT.
      clearMem(1'b0);
      putWord(SA, 20'h00002);
      putWord(SA + 1, 20'h00008);
      resetA();
      applyStimulus();
      checkOutput("legacy add acc", 32'(dataOutA), 32'd1);
      applyStimulus();
      checkOutput("halt addr", 32'(addrOutA), 32'(SA + 1));
      applyStimulus();

      // LOAD / STORE round trip through data address 0.
      clearMem(1'b0);
      putWord(0, 20'h01234);
      putWord(SA, 20'h00000);
      putWord(SA + 1, 20'h00001);
      putWord(SA + 2, 20'h00008);
      resetA();
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("load store mem0", 32'(memA[0]), 32'h1234);
      checkOutput("load store acc", 32'(dataOutA), 32'h1234);

      // BZ not taken.
      clearMem(1'b0);
      putWord(SA, 20'h00022);
      putWord(SA + 1, 20'h00055);
      putWord(SA + 2, 20'h00008);
      resetA();
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("bz not taken halt", 32'(addrOutA), 32'(SA + 2));

      // BZ taken.
      clearMem(1'b0);
      putWord(SA, 20'h00006);
      putWord(SA + 1, 20'h00055);
      putWord(SA + 2, 20'h00008);
      putWord(SA + 5, 20'h00008);
      resetA();
      applyStimulus();
      applyStimulus();
      checkOutput("bz taken pc", 32'(addrOutA), 32'(SA + 5));
      applyStimulus();
      checkOutput("bz taken halted", 32'(haltedA), 32'd1);

      // Data pointer wrap via INCDP at and below the limit, exposed by STORE.
      clearMem(1'b1);
      putWord(SA, 20'h1F406);
      putWord(SA + 1, 20'h00007);
      putWord(SA + 2, 20'h00001);
      putWord(SA + 3, 20'h1F3F6);
      putWord(SA + 4, 20'h00007);
      putWord(SA + 5, 20'h00001);
      putWord(SA + 6, 20'h00008);
      resetA();
      for (int i = 0; i < 7; i++) applyStimulus();
      checkOutput("dptr 8000 store", 32'(memA[8000]), 32'd0);

      // LOOP from dptr 8000 wraps to 0.
      clearMem(1'b1);
      putWord(SA, 20'h00001);
      putWord(SA + 1, 20'h1F406);
      putWord(SA + 2, 20'h00003);
      resetA();
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("loop pc", 32'(addrOutA), 32'(SA));
      applyStimulus();

      // Reset during the write clock: strobe drops at once, no write lands.
      clearMem(1'b1);
      putWord(SA, 20'h00052);
      putWord(SA + 1, 20'h00001);
      putWord(SA + 2, 20'h00008);
      resetA();
      applyStimulus();
      tickClock(3 * CD);
      checkOutput("we before reset", 32'(weA), 32'd1);
      #2;
      resetA_n = 1'b0;
      #1;
      checkOutput("we async drop", 32'(weA), 32'd0);
      tickClock(2);
      checkOutput("no write on reset", 32'(memA[0]), 32'(mMem[0]));
      resetA_n = 1'b1;
      mAcc = 0;
      mPc = SA;
      mDptr = 0;
      mHalted = 1'b0;
      checkOutput("post reset pc", 32'(addrOutA), 32'(SA));
      checkOutput("post reset acc", 32'(dataOutA), 32'd0);
      applyStimulus();

      // Random programs.
      for (int p = 0; p < 4; p++) begin
         clearMem(1'b1);
         for (int i = 0; i < 16; i++) putWord(SA + i, randomWord());
         resetA();
         for (int s = 0; s < 24; s++) applyStimulus();
      end

      // Narrow core, START_ADDR 0, one tick per clock.
      resetA_n = 1'b0;
      memB[0]  = 8'h86;
      memB[1]  = 8'h00;
      memB[2]  = 8'hF2;
      memB[3]  = 8'hF4;
      memB[8]  = 8'd250;
      memB[15] = 8'h08;
      tickClock(1);
      resetB_n = 1'b1;
      checkOutput("B reset addr", 32'(addrOutB), 32'd0);
      tickClock(4);
      checkOutput("B setdp pc", 32'(addrOutB), 32'd1);
      tickClock(2);
      checkOutput("B load addr", 32'(addrOutB), 32'd8);
      tickClock(2);
      checkOutput("B load acc", 32'(dataOutB), 32'd250);
      checkOutput("B load pc", 32'(addrOutB), 32'd2);
      tickClock(4);
      checkOutput("B add wrap acc", 32'(dataOutB), 32'd9);
      tickClock(4);
      checkOutput("B jmp pc", 32'(addrOutB), 32'd15);
      checkOutput("B not halted", 32'(haltedB), 32'd0);
      tickClock(4);
      checkOutput("B halted", 32'(haltedB), 32'd1);
      checkOutput("B halt addr", 32'(addrOutB), 32'd15);
      checkOutput("B we idle", 32'(weB), 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
